// File: rtl/program_loader_sequencer.sv
// program_loader_sequencer
//   Boot/run sequencer for a MIPS core. It holds the core in reset and accepts a
//   program as a byte stream (valid/ready). Bytes are packed little-endian into
//   32-bit words, and each word is written to program memory through a one-cycle
//   write strobe. After the last word the core is released. While the core runs,
//   the block watches for halt and reload requests.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous reset, active low
//   start        : begin a (re)load; honoured in IDLE, RUN and ERROR
//   halt         : stop the core or abort a load in progress
//   byte_data    : program stream byte
//   byte_valid   : byte_data is valid
//   byte_ready   : loader can accept a byte this cycle
//   pm_we        : program memory write strobe, one cycle per word
//   pm_addr      : byte address of the word being written (word index * 4)
//   pm_wdata     : assembled word
//   cpu_reset_n  : processor reset, low holds the core in reset
//   busy         : loading (HEADER/DATA/WRITE)
//   done         : core released and running
//   error        : 0 none, 1 bad header, 2 timeout
//   loaded_words : words written in the current or last load
module program_loader_sequencer #(
  parameter int MEMORY_DEPTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        pm_we,
  output logic [31:0] pm_addr,
  output logic [31:0] pm_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [7:0]  loaded_words
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [7:0]  DEPTH_BYTES  = 8'(MEMORY_DEPTH);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wordCount;
  logic [7:0]  wordIdx;
  logic [1:0]  byteIdx;
  logic [15:0] timeoutCnt;
  logic        accept;
  logic        startLoad;

  // byte_ready is only ever high in HEADER/DATA, so this is a true handshake.
  assign accept = byte_valid && byte_ready;

  // start is only honoured outside a load. Evaluating it ahead of the state case
  // gives it priority over a simultaneous halt in RUN and ERROR.
  assign startLoad = start && ((state == IDLE) || (state == RUN) || (state == ERROR));

  // Single registered FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      pm_we        <= 1'b0;
      pm_addr      <= 32'd0;
      pm_wdata     <= 32'd0;
      cpu_reset_n  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 2'd0;
      loaded_words <= 8'd0;
      wordCount    <= 8'd0;
      wordIdx      <= 8'd0;
      byteIdx      <= 2'd0;
      timeoutCnt   <= 16'd0;
    end else begin
      // The strobe is raised only on the edge entering WRITE, so it lasts one cycle.
      pm_we <= 1'b0;
      if (startLoad) begin
        state        <= HEADER;
        byte_ready   <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        cpu_reset_n  <= 1'b0;
        error        <= 2'd0;
        loaded_words <= 8'd0;
        wordIdx      <= 8'd0;
        byteIdx      <= 2'd0;
        timeoutCnt   <= 16'd0;
      end else begin
        case (state)
          IDLE: ;
          HEADER, DATA: begin
            // halt wins over a byte offered in the same cycle.
            if (halt) begin
              state      <= IDLE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else if (accept) begin
              timeoutCnt <= 16'd0;
              if (state == HEADER) begin
                if ((byte_data == 8'd0) || (byte_data > DEPTH_BYTES)) begin
                  state      <= ERROR;
                  error      <= 2'd1;
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                end else begin
                  wordCount <= byte_data;
                  state     <= DATA;
                end
              end else begin
                pm_wdata[{byteIdx, 3'b000} +: 8] <= byte_data;
                byteIdx <= byteIdx + 2'd1;
                if (byteIdx == 2'd3) begin
                  state      <= WRITE;
                  byte_ready <= 1'b0;
                  pm_we      <= 1'b1;
                  pm_addr    <= {22'd0, wordIdx, 2'b00};
                end
              end
            end else if (timeoutCnt == TIMEOUT_LAST) begin
              // A partial word is simply dropped; nothing is written.
              state      <= ERROR;
              error      <= 2'd2;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              timeoutCnt <= timeoutCnt + 16'd1;
            end
          end
          WRITE: begin
            // The strobe has already gone out, so the word counts even if halted.
            loaded_words <= wordIdx + 8'd1;
            wordIdx      <= wordIdx + 8'd1;
            if (halt) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (wordIdx == wordCount - 8'd1) begin
              state       <= RUN;
              busy        <= 1'b0;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state      <= DATA;
              byte_ready <= 1'b1;
              timeoutCnt <= 16'd0;
            end
          end
          RUN: begin
            if (halt) begin
              state       <= IDLE;
              done        <= 1'b0;
              cpu_reset_n <= 1'b0;
            end
          end
          ERROR: begin
            if (halt) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader_sequencer.sv
// tb_program_loader_sequencer
//   Directed bench for program_loader_sequencer. Expected memory writes are
//   queued as bytes are streamed. A monitor pops the queue and compares each
//   time the loader raises pm_we. The bench stimulates the DUT from the clock,
//   reset and all inputs, and observes every output.
module tb_program_loader_sequencer;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        pm_we;
  logic [31:0] pm_addr;
  logic [31:0] pm_wdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [7:0]  loaded_words;

  int checks   = 0;
  int failures = 0;
  int weCount  = 0;
  logic [63:0] expQ[$];

  program_loader_sequencer #(
    .MEMORY_DEPTH  (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .pm_we       (pm_we),
    .pm_addr     (pm_addr),
    .pm_wdata    (pm_wdata),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued word.
  // byte_ready must be low while the strobe is high.
  always @(negedge clk) begin
    if (reset && pm_we) begin
      weCount++;
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $display("[TB] FAIL we_unexpected: observed addr=%h data=%h expected no write", pm_addr, pm_wdata);
        $error("[TB] unexpected write");
      end
      if (expQ.size() != 0) begin
        logic [63:0] e;
        e = expQ.pop_front();
        checkOutput("we_addr", pm_addr, e[63:32]);
        checkOutput("we_data", pm_wdata, e[31:0]);
      end
      checkOutput("ready_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte, optionally after a gap. The task waits (bounded) for ready,
  // then returns just after the accepting edge with byte_valid still high.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCycles;
    waitCycles = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (waitCycles >= 50) checkOutput("ready_wait", 32'(byte_ready), 32'd1);
    tick();
  endtask

  // Full load of n random words from HEADER, ending one cycle into RUN.
  task automatic loadProgram(input int n, input bit randomGaps);
    logic [31:0] word;
    applyStimulus(8'(n), 0);
    for (int w = 0; w < n; w++) begin
      word = $urandom;
      expQ.push_back({32'(w * 4), word});
      for (int k = 0; k < 4; k++)
        applyStimulus(word[8*k +: 8], randomGaps ? int'($urandom_range(0, 3)) : 0);
    end
    byte_valid = 1'b0;
    checkOutput("load_last_we", 32'(pm_we), 32'd1);
    tick();
    checkOutput("load_done", 32'(done), 32'd1);
    checkOutput("load_cpu_rst", 32'(cpu_reset_n), 32'd1);
    checkOutput("load_words", 32'(loaded_words), 32'(n));
    checkOutput("load_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedWe;
    int idle;
    reset = 1'b0; start = 1'b0; halt = 1'b0; byte_data = 8'h00; byte_valid = 1'b0;
    #1;
    checkOutput("rst_cpu", 32'(cpu_reset_n), 32'd0);
    checkOutput("rst_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_words", 32'(loaded_words), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Basic two-word load with known data.
    $display("[TB] test 1: two-word load");
    pulseStart();
    checkOutput("hdr_ready", 32'(byte_ready), 32'd1);
    checkOutput("hdr_busy", 32'(busy), 32'd1);
    expQ.push_back({32'd0, 32'h0001_0820});
    expQ.push_back({32'd4, 32'h1122_3344});
    applyStimulus(8'h02, 0);
    applyStimulus(8'h20, 0); applyStimulus(8'h08, 0); applyStimulus(8'h01, 0); applyStimulus(8'h00, 0);
    applyStimulus(8'h44, 0); applyStimulus(8'h33, 0); applyStimulus(8'h22, 0); applyStimulus(8'h11, 0);
    byte_valid = 1'b0;
    checkOutput("t1_we", 32'(pm_we), 32'd1);
    checkOutput("t1_done_early", 32'(done), 32'd0);
    checkOutput("t1_cpu_early", 32'(cpu_reset_n), 32'd0);
    tick();
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_cpu", 32'(cpu_reset_n), 32'd1);
    checkOutput("t1_words", 32'(loaded_words), 32'd2);
    checkOutput("t1_we_off", 32'(pm_we), 32'd0);
    checkOutput("t1_writes", 32'(weCount), 32'd2);

    // halt in RUN, then start+halt together, then halt against a byte.
    $display("[TB] test 6: halt and start in RUN");
    halt = 1'b1; tick(); halt = 1'b0;
    checkOutput("t6_cpu", 32'(cpu_reset_n), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    checkOutput("t6_ready", 32'(byte_ready), 32'd0);
    pulseStart();
    loadProgram(1, 1'b0);
    start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
    checkOutput("t6_sh_busy", 32'(busy), 32'd1);
    checkOutput("t6_sh_cpu", 32'(cpu_reset_n), 32'd0);
    checkOutput("t6_sh_ready", 32'(byte_ready), 32'd1);
    byte_data = 8'h01; byte_valid = 1'b1; halt = 1'b1; tick(); halt = 1'b0; byte_valid = 1'b0;
    checkOutput("t6_hp_busy", 32'(busy), 32'd0);
    checkOutput("t6_hp_err", 32'(error), 32'd0);

    // Bad headers, then recovery.
    $display("[TB] test 2: bad headers");
    savedWe = weCount;
    pulseStart();
    applyStimulus(8'h00, 0); byte_valid = 1'b0;
    checkOutput("t2_err0", 32'(error), 32'd1);
    checkOutput("t2_ready0", 32'(byte_ready), 32'd0);
    pulseStart();
    applyStimulus(8'd33, 0); byte_valid = 1'b0;
    checkOutput("t2_err33", 32'(error), 32'd1);
    checkOutput("t2_cpu", 32'(cpu_reset_n), 32'd0);
    checkOutput("t2_no_we", 32'(weCount), 32'(savedWe));
    pulseStart();
    checkOutput("t2_err_clr", 32'(error), 32'd0);
    loadProgram(3, 1'b0);
    checkOutput("t2_err_after", 32'(error), 32'd0);

    // Timeout mid-word.
    $display("[TB] test 3: timeout");
    savedWe = weCount;
    pulseStart();
    applyStimulus(8'h01, 0); applyStimulus(8'hAA, 0); applyStimulus(8'hBB, 0);
    byte_valid = 1'b0;
    idle = 0;
    while (error != 2'd2 && idle < TIMEOUT + 20) begin
      tick();
      idle++;
    end
    checkOutput("t3_err", 32'(error), 32'd2);
    checkOutput("t3_idle", 32'(idle), 32'(TIMEOUT));
    checkOutput("t3_cpu", 32'(cpu_reset_n), 32'd0);
    checkOutput("t3_no_we", 32'(weCount), 32'(savedWe));
    halt = 1'b1; tick(); halt = 1'b0;
    checkOutput("t3_err_kept", 32'(error), 32'd2);

    // Full-depth load with valid held through WRITE and random gaps.
    $display("[TB] test 4: full-depth load with gaps");
    pulseStart();
    loadProgram(DEPTH, 1'b1);

    // Async reset mid-DATA.
    $display("[TB] test 5: async reset mid-load");
    pulseStart();
    applyStimulus(8'h04, 0); applyStimulus(8'hAA, 0); applyStimulus(8'hBB, 0);
    byte_valid = 1'b0;
    checkOutput("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_ready", 32'(byte_ready), 32'd0);
    checkOutput("t5_wdata", pm_wdata, 32'd0);
    checkOutput("t5_words", 32'(loaded_words), 32'd0);
    checkOutput("t5_misc", {26'd0, pm_we, cpu_reset_n, done, error, 1'b0}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    pulseStart();
    loadProgram(2, 1'b0);

    tick();
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
